io_uart_responder: RTL and testbench

- Peripheral end of the CPU's I/O strobes (WrOut / InNoe). It is a memory-less responder on the 8-bit data bus.
- A CPU output write (WrOut) pushes the bus byte into a TX FIFO, which is serialized as 8N1 UART.
- A CPU input read (InNoe low) places the last received UART byte on the bus.
- Status flags are exported so microcode or flag logic can poll.

---
 rtl/io_uart_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_io_uart_responder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_responder.sv
// rtl/io_uart_responder.sv - CPU I/O strobe responder with TX FIFO and 8N1 UART (optional IO_UART_LOOPBACK_EN)
module io_uart_responder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_bus,
    input  logic       i_ctrlWrOut,
    input  logic       i_ctrlInNoe,
    output logic [7:0] o_bus,
    output logic       o_busOE,
    input  logic       i_uartRx,
`ifdef IO_UART_LOOPBACK_EN
    input  logic       i_loopback,
`endif
    output logic       o_uartTx,
    output logic       o_txFull,
    output logic       o_txBusy,
    output logic       o_rxValid,
    output logic       o_txOverflow,
    output logic       o_rxOverrun,
    output logic       o_rxFrameErr
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH     = CW'(TX_DEPTH);
    localparam logic [7:0]    BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    logic [1:0] tx_state;
    logic [7:0] tx_timer;
    logic [7:0] tx_shift;
    logic [2:0] tx_idx;
    logic       tx_line;

    logic       rx_src;
    logic       sync1;
    logic       sync2;
    logic       rx_prev;
    logic [1:0] rx_state;
    logic [7:0] rx_timer;
    logic [7:0] rx_shift;
    logic [2:0] rx_idx;
    logic       rx_brk;
    logic       rx_done;
    logic [7:0] rx_hold;
    logic       rx_valid;
    logic       inoe_q;
    logic       read_edge;

    logic tx_overflow;
    logic rx_overrun;
    logic rx_frame_err;

    // The shifter takes the next byte both from IDLE and at the end of STOP, so frames run back-to-back.
    assign pop  = (count != '0) &&
                  ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_timer == 8'd0)));
    assign push = i_ctrlWrOut && ((count != DEPTH) || pop);

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_bus;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_ctrlWrOut && !push) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state <= ST_IDLE;
            tx_timer <= 8'd0;
            tx_shift <= 8'd0;
            tx_idx   <= 3'd0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_timer <= BIT_LAST;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_timer == 8'd0) begin
                        tx_timer <= BIT_LAST;
                        tx_idx   <= 3'd0;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_timer <= tx_timer - 8'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_timer == 8'd0) begin
                        tx_timer <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_timer <= tx_timer - 8'd1;
                    end
                end
                default: begin
                    if (tx_timer == 8'd0) begin
                        if (pop) begin
                            tx_shift <= fifo_mem[rd_ptr];
                            tx_timer <= BIT_LAST;
                            tx_state <= ST_START;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_timer <= tx_timer - 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            ST_START: tx_line = 1'b0;
            ST_DATA:  tx_line = tx_shift[tx_idx];
            default:  tx_line = 1'b1;
        endcase
    end

`ifdef IO_UART_LOOPBACK_EN
    assign rx_src   = i_loopback ? tx_line : i_uartRx;
    assign o_uartTx = i_loopback ? 1'b1 : tx_line;
`else
    assign rx_src   = i_uartRx;
    assign o_uartTx = tx_line;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_src;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // A good stop bit completes a byte; the holding register decides whether it is kept.
    assign rx_done = (rx_state == ST_STOP) && !rx_brk && (rx_timer == BIT_LAST) && sync2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_state     <= ST_IDLE;
            rx_timer     <= 8'd0;
            rx_shift     <= 8'd0;
            rx_idx       <= 3'd0;
            rx_brk       <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !sync2) begin
                        rx_timer <= 8'd0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= 8'd0;
                        rx_idx   <= 3'd0;
                        rx_state <= sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_timer <= rx_timer + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= 8'd0;
                        rx_shift <= {sync2, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 8'd1;
                    end
                end
                default: begin
                    if (rx_brk) begin
                        if (sync2) begin
                            rx_brk   <= 1'b0;
                            rx_state <= ST_IDLE;
                        end
                    end else if (rx_timer == BIT_LAST) begin
                        if (sync2) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_brk       <= 1'b1;
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 8'd1;
                    end
                end
            endcase
        end
    end

    assign read_edge = inoe_q && !i_ctrlInNoe;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            inoe_q     <= 1'b1;
            rx_hold    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            inoe_q <= i_ctrlInNoe;
            if (rx_done) begin
                if (!rx_valid || read_edge) begin
                    rx_hold  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (read_edge) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign o_busOE      = ~i_ctrlInNoe;
    assign o_bus        = i_ctrlInNoe ? 8'h00 : rx_hold;
    assign o_txFull     = (count == DEPTH);
    assign o_txBusy     = (count != '0) || (tx_state != ST_IDLE);
    assign o_rxValid    = rx_valid;
    assign o_txOverflow = tx_overflow;
    assign o_rxOverrun  = rx_overrun;
    assign o_rxFrameErr = rx_frame_err;

endmodule

// File: tb/tb_io_uart_responder.sv
// tb/tb_io_uart_responder.sv - randomized self-checking bench for io_uart_responder
module tb_io_uart_responder;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_in;
    logic       wr_out;
    logic       in_noe;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       uart_rx;
    logic       uart_tx;
    logic       tx_full;
    logic       tx_busy;
    logic       rx_valid;
    logic       tx_overflow;
    logic       rx_overrun;
    logic       rx_frame_err;
`ifdef IO_UART_LOOPBACK_EN
    logic       loopback;
`endif

    int checks   = 0;
    int failures = 0;

    bit         exp_q[$];
    logic [7:0] m_hold;
    bit         m_valid;
    bit         m_overrun;
    bit         m_ferr;

    always #5 clk = ~clk;

    io_uart_responder #(.CLKS_PER_BIT(C), .TX_DEPTH(D)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_bus(bus_in),
        .i_ctrlWrOut(wr_out),
        .i_ctrlInNoe(in_noe),
        .o_bus(bus_out),
        .o_busOE(bus_oe),
        .i_uartRx(uart_rx),
`ifdef IO_UART_LOOPBACK_EN
        .i_loopback(loopback),
`endif
        .o_uartTx(uart_tx),
        .o_txFull(tx_full),
        .o_txBusy(tx_busy),
        .o_rxValid(rx_valid),
        .o_txOverflow(tx_overflow),
        .o_rxOverrun(rx_overrun),
        .o_rxFrameErr(rx_frame_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        wr_out  = 1'b0;
        bus_in  = 8'h00;
        in_noe  = 1'b1;
        uart_rx = 1'b1;
`ifdef IO_UART_LOOPBACK_EN
        loopback = 1'b0;
`endif
        tick();
        tick();
        reset     = 1'b0;
        m_hold    = 8'h00;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_ferr    = 1'b0;
    endtask

    // Expected 8N1 line levels, one entry per clock cycle.
    task automatic add_frame(input logic [7:0] data);
        for (int k = 0; k < C; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < C; k++) exp_q.push_back(data[b]);
        for (int k = 0; k < C; k++) exp_q.push_back(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (C) tick();
        end
        uart_rx = 1'b1;
        if (!stop_bit) m_ferr = 1'b1;
        else if (m_valid) m_overrun = 1'b1;
        else begin
            m_hold  = data;
            m_valid = 1'b1;
        end
        repeat (6) tick();
    endtask

    task automatic check_rx_flags(input string tag);
        checks++;
        if (rx_valid !== m_valid || rx_overrun !== m_overrun || rx_frame_err !== m_ferr) begin
            failures++;
            $display("FAIL %s flags valid/overrun/ferr got=%b%b%b want=%b%b%b", tag,
                     rx_valid, rx_overrun, rx_frame_err, m_valid, m_overrun, m_ferr);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        in_noe = 1'b1;
        tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_full !== 1'b0 || tx_busy !== 1'b0 || rx_valid !== 1'b0 ||
            tx_overflow !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0 ||
            bus_out !== 8'h00 || bus_oe !== 1'b0) begin
            failures++;
            $display("FAIL reset_state tx=%b full=%b busy=%b rxv=%b ovf=%b ovr=%b fe=%b bus=%h oe=%b want tx=1 others 0",
                     uart_tx, tx_full, tx_busy, rx_valid, tx_overflow, rx_overrun, rx_frame_err, bus_out, bus_oe);
        end
        do_reset();
    endtask

    task automatic test_tx_single;
        do_reset();
        exp_q.delete();
        exp_q.push_back(1'b1);
        add_frame(8'hA5);
        bus_in = 8'hA5;
        wr_out = 1'b1;
        tick();
        wr_out = 1'b0;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (uart_tx !== exp_q[n] || tx_busy !== 1'b1) begin
                failures++;
                $display("FAIL tx_single cycle %0d tx=%b busy=%b want tx=%b busy=1", n, uart_tx, tx_busy, exp_q[n]);
            end
            tick();
        end
        checks++;
        if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL tx_single_end busy=%b tx=%b want busy=0 tx=1", tx_busy, uart_tx);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [6];
        do_reset();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(0, 255));
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 5; i++) add_frame(b[i]);
        bus_in = b[0];
        wr_out = 1'b1;
        tick();
        wr_out = 1'b0;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (uart_tx !== exp_q[n]) begin
                failures++;
                $display("FAIL b2b_line cycle %0d tx=%b want %b", n, uart_tx, exp_q[n]);
            end
            if (n == 5) begin
                checks++;
                if (tx_full !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_not_full full=%b want 0", tx_full);
                end
            end
            if (n == 6) begin
                checks++;
                if (tx_full !== 1'b1 || tx_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full full=%b ovf=%b want 1 0", tx_full, tx_overflow);
                end
            end
            if (n == 7) begin
                checks++;
                if (tx_overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_overflow ovf=%b want 1", tx_overflow);
                end
            end
            wr_out = (n >= 2 && n <= 6);
            bus_in = (n >= 2 && n <= 6) ? b[n - 1] : 8'h00;
            tick();
        end
        checks++;
        if (tx_busy !== 1'b0 || tx_full !== 1'b0 || uart_tx !== 1'b1 || tx_overflow !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end busy=%b full=%b tx=%b ovf=%b want 0 0 1 1", tx_busy, tx_full, uart_tx, tx_overflow);
        end
    endtask

    task automatic test_rx_read;
        do_reset();
        send_frame(8'h3C, 1'b1);
        check_rx_flags("rx_3c");
        in_noe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus_out !== m_hold || bus_oe !== 1'b1) begin
                failures++;
                $display("FAIL rx_read_bus cycle %0d bus=%h oe=%b want %h 1", i, bus_out, bus_oe, m_hold);
            end
            tick();
            m_valid = 1'b0;
            check_rx_flags("rx_read_hold");
        end
        in_noe = 1'b1;
        tick();
        in_noe = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h3C) begin
            failures++;
            $display("FAIL rx_stale_read bus=%h want 3c", bus_out);
        end
        tick();
        in_noe = 1'b1;
        check_rx_flags("rx_stale_flags");
    endtask

    task automatic test_rx_random;
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom_range(0, 255));
            send_frame(v, 1'b1);
            check_rx_flags("rx_rand");
            in_noe = 1'b0;
            #1;
            checks++;
            if (bus_out !== m_hold) begin
                failures++;
                $display("FAIL rx_rand_byte %0d bus=%h want %h", i, bus_out, m_hold);
            end
            tick();
            in_noe  = 1'b1;
            m_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_overrun;
        logic [7:0] a;
        logic [7:0] b;
        do_reset();
        a = 8'($urandom_range(0, 255));
        b = ~a;
        send_frame(a, 1'b1);
        send_frame(b, 1'b1);
        check_rx_flags("overrun");
        in_noe = 1'b0;
        #1;
        checks++;
        if (bus_out !== a) begin
            failures++;
            $display("FAIL overrun_hold bus=%h want %h", bus_out, a);
        end
        tick();
        in_noe = 1'b1;
    endtask

    task automatic test_frame_err_glitch;
        logic [7:0] v;
        do_reset();
        send_frame(8'($urandom_range(0, 255)), 1'b0);
        check_rx_flags("frame_err");
        do_reset();
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        check_rx_flags("glitch");
        v = 8'($urandom_range(0, 255));
        send_frame(v, 1'b1);
        check_rx_flags("after_glitch");
        in_noe = 1'b0;
        #1;
        checks++;
        if (bus_out !== v) begin
            failures++;
            $display("FAIL after_glitch_byte bus=%h want %h", bus_out, v);
        end
        tick();
        in_noe = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus_in = 8'($urandom_range(0, 255));
            wr_out = 1'b1;
            tick();
        end
        wr_out  = 1'b0;
        uart_rx = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0 || tx_overflow !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid tx=%b busy=%b full=%b ovf=%b rxv=%b want 1 0 0 0 0",
                     uart_tx, tx_busy, tx_full, tx_overflow, rx_valid);
        end
        uart_rx = 1'b1;
        reset   = 1'b0;
        tick();
    endtask

`ifdef IO_UART_LOOPBACK_EN
    task automatic test_loopback;
        do_reset();
        loopback = 1'b1;
        bus_in   = 8'h5A;
        wr_out   = 1'b1;
        tick();
        wr_out = 1'b0;
        for (int n = 0; n < 60; n++) begin
            checks++;
            if (uart_tx !== 1'b1) begin
                failures++;
                $display("FAIL loopback_tx_idle cycle %0d tx=%b want 1", n, uart_tx);
            end
            tick();
        end
        m_hold  = 8'h5A;
        m_valid = 1'b1;
        check_rx_flags("loopback_rx");
        in_noe = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h5A) begin
            failures++;
            $display("FAIL loopback_byte bus=%h want 5a", bus_out);
        end
        tick();
        in_noe = 1'b1;
        bus_in = 8'h33;
        wr_out = 1'b1;
        tick();
        wr_out = 1'b0;
        repeat (12) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL loopback_reset tx=%b busy=%b rxv=%b fe=%b want 1 0 0 0", uart_tx, tx_busy, rx_valid, rx_frame_err);
        end
        reset    = 1'b0;
        loopback = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset   = 1'b1;
        wr_out  = 1'b0;
        bus_in  = 8'h00;
        in_noe  = 1'b1;
        uart_rx = 1'b1;
`ifdef IO_UART_LOOPBACK_EN
        loopback = 1'b0;
`endif
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_read();
        test_rx_random();
        test_overrun();
        test_frame_err_glitch();
        test_reset_mid();
`ifdef IO_UART_LOOPBACK_EN
        test_loopback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
